// File: rtl/ai_seq_pkg.sv
`default_nettype none
// ai_seq_pkg: state encoding, error codes and defaults shared by the AI sector sequencer.
// Rev 1.0
package ai_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    REQ  = 3'd2,
    XFER = 3'd3,
    DONE = 3'd4,
    FAIL = 3'd5
  } seq_state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CRC  = 2'd1;
  localparam logic [1:0] ERR_TMR  = 2'd2;
  localparam logic [1:0] ERR_WDOG = 2'd3;

  localparam int DEF_SECTOR_BYTES = 512;

endpackage
`default_nettype wire

// File: rtl/ai_seq_watchdog.sv
`default_nettype none
// ai_seq_watchdog: loadable inactivity counter; expired pulses while enabled at count CYCLES-1.
// Rev 1.0
module ai_seq_watchdog #(
  parameter int CYCLES = 1000000,
  parameter int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  // Expiry looks at the accumulated count, so activity in the final cycle does not rescue it.
  assign expired = en && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/ai_sector_sequencer.sv
`default_nettype none
// ai_sector_sequencer: multi-sector read sequencer between AI control and the card reader / byte buffer.
// Rev 1.0
module ai_sector_sequencer
  import ai_seq_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int CNT_W        = 16,
  parameter int SECTOR_BYTES = DEF_SECTOR_BYTES,
  parameter int MAX_RETRY    = 3,
  parameter int WDOG_CYCLES  = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_sector,
  input  logic [CNT_W-1:0]  sector_count,
  output logic              card_req,
  output logic [ADDR_W-1:0] card_addr,
  input  logic              card_rdy,
  output logic              buf_init,
  input  logic              buf_data_rdy,
  input  logic              buf_crc_err,
  input  logic              buf_tmr_err,
  output logic              busy,
  output logic              sector_done,
  output logic              discard,
  output logic              done,
  output logic              fail,
  output logic [1:0]        err_code
);

  localparam int BYTE_W = $clog2(SECTOR_BYTES + 1);
  localparam int WD_W   = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(SECTOR_BYTES - 1);

  seq_state_t        state, state_nxt;
  logic [ADDR_W-1:0] cur_sector, cur_sector_nxt, card_addr_nxt;
  logic [CNT_W-1:0]  remaining, remaining_nxt;
  logic [2:0]        retry, retry_nxt;
  logic [BYTE_W-1:0] byte_cnt, byte_cnt_nxt;
  logic [1:0]        err_code_nxt, err_kind;
  logic              card_req_nxt, buf_init_nxt, sector_done_nxt, discard_nxt;
  logic              done_nxt, fail_nxt, busy_nxt;
  logic              in_xfer, wdog_clr, wdog_expired, err_hit, last_byte;

  assign in_xfer  = (state == XFER);
  assign wdog_clr = !in_xfer || card_rdy;

  ai_seq_watchdog #(
    .CYCLES (WDOG_CYCLES),
    .CNT_W  (WD_W)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr      (wdog_clr),
    .load     (1'b0),
    .load_val ({WD_W{1'b0}}),
    .en       (in_xfer),
    .expired  (wdog_expired)
  );

  assign err_hit   = in_xfer && (buf_crc_err || buf_tmr_err || wdog_expired);
  assign last_byte = buf_data_rdy && (byte_cnt == LAST_BYTE);
  assign err_kind  = buf_crc_err ? ERR_CRC : (buf_tmr_err ? ERR_TMR : ERR_WDOG);

  always_comb begin
    state_nxt       = state;
    cur_sector_nxt  = cur_sector;
    remaining_nxt   = remaining;
    retry_nxt       = retry;
    byte_cnt_nxt    = byte_cnt;
    card_addr_nxt   = card_addr;
    fail_nxt        = fail;
    err_code_nxt    = err_code;
    card_req_nxt    = 1'b0;
    buf_init_nxt    = 1'b0;
    sector_done_nxt = 1'b0;
    discard_nxt     = 1'b0;
    done_nxt        = 1'b0;

    if (abort) begin
      // The buffer keeps a lock until re-initialised, so abort always pulses buf_init.
      state_nxt    = IDLE;
      buf_init_nxt = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cur_sector_nxt = base_sector;
            remaining_nxt  = sector_count;
            retry_nxt      = 3'd0;
            fail_nxt       = 1'b0;
            err_code_nxt   = ERR_NONE;
            if (sector_count == '0) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt    = INIT;
              buf_init_nxt = 1'b1;
            end
          end
        end
        INIT: begin
          byte_cnt_nxt  = '0;
          state_nxt     = REQ;
          card_req_nxt  = 1'b1;
          card_addr_nxt = cur_sector;
        end
        REQ: begin
          state_nxt = XFER;
        end
        XFER: begin
          if (buf_data_rdy) begin
            byte_cnt_nxt = byte_cnt + BYTE_W'(1);
          end
          if (err_hit) begin
            if ((int'(retry) + 1) < MAX_RETRY) begin
              retry_nxt    = retry + 3'd1;
              discard_nxt  = 1'b1;
              state_nxt    = INIT;
              buf_init_nxt = 1'b1;
            end else begin
              state_nxt    = FAIL;
              fail_nxt     = 1'b1;
              err_code_nxt = err_kind;
            end
          end else if (last_byte) begin
            sector_done_nxt = 1'b1;
            cur_sector_nxt  = cur_sector + ADDR_W'(1);
            remaining_nxt   = remaining - CNT_W'(1);
            retry_nxt       = 3'd0;
            if (remaining == CNT_W'(1)) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt    = INIT;
              buf_init_nxt = 1'b1;
            end
          end
        end
        DONE:    state_nxt = IDLE;
        FAIL:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    busy_nxt = (state_nxt == INIT) || (state_nxt == REQ) || (state_nxt == XFER);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cur_sector  <= '0;
      remaining   <= '0;
      retry       <= 3'd0;
      byte_cnt    <= '0;
      card_addr   <= '0;
      card_req    <= 1'b0;
      buf_init    <= 1'b0;
      sector_done <= 1'b0;
      discard     <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      err_code    <= ERR_NONE;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cur_sector  <= cur_sector_nxt;
      remaining   <= remaining_nxt;
      retry       <= retry_nxt;
      byte_cnt    <= byte_cnt_nxt;
      card_addr   <= card_addr_nxt;
      card_req    <= card_req_nxt;
      buf_init    <= buf_init_nxt;
      sector_done <= sector_done_nxt;
      discard     <= discard_nxt;
      done        <= done_nxt;
      fail        <= fail_nxt;
      err_code    <= err_code_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ai_sector_sequencer.sv
`default_nettype none
// tb_ai_sector_sequencer: directed table, hand sequences and randomized runs against a transaction model.
// Rev 1.0
module tb_ai_sector_sequencer;

  localparam int MAX_RETRY = 3;
  localparam int WDOG      = 100;

  logic        clk = 1'b0;
  logic        rst, start, abort, card_rdy, buf_data_rdy, buf_crc_err, buf_tmr_err;
  logic [31:0] base_sector;
  logic [15:0] sector_count;
  logic        card_req, buf_init, busy, sector_done, discard, done, fail;
  logic [31:0] card_addr;
  logic [1:0]  err_code;

  ai_sector_sequencer #(
    .ADDR_W(32), .CNT_W(16), .SECTOR_BYTES(512), .MAX_RETRY(MAX_RETRY), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_sector(base_sector), .sector_count(sector_count),
    .card_req(card_req), .card_addr(card_addr), .card_rdy(card_rdy),
    .buf_init(buf_init), .buf_data_rdy(buf_data_rdy),
    .buf_crc_err(buf_crc_err), .buf_tmr_err(buf_tmr_err),
    .busy(busy), .sector_done(sector_done), .discard(discard),
    .done(done), .fail(fail), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Monitor: running totals of every pulse, plus the address of each read command.
  int tot_req = 0, tot_init = 0, tot_sdone = 0, tot_disc = 0, tot_done = 0;
  logic [31:0] req_addr_q[$];

  always @(negedge clk) begin
    if (card_req) begin
      tot_req++;
      req_addr_q.push_back(card_addr);
    end
    if (buf_init)    tot_init++;
    if (sector_done) tot_sdone++;
    if (discard)     tot_disc++;
    if (done)        tot_done++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!card_req && n < 300) begin
      step();
      n++;
    end
    chk(name, card_req, 1);
  endtask

  // Attempt kinds: 0 clean, 1 CRC, 2 timeout, 3 CRC+timeout, 4 silent card, 5 timeout with final byte.
  function automatic int pick_kind();
    int r = $urandom_range(0, 9);
    if (r < 6) return 0;
    if (r == 6) return 1;
    if (r == 7) return 2;
    if (r == 8) return 3;
    return 5;
  endfunction

  int m_req, m_sdone, m_disc, m_done, m_fail, m_err;
  int d_req, d_init, d_sdone, d_disc, d_done, d_addr_bad;
  logic [31:0] m_addr_q[$];

  task automatic run_case(input logic [31:0] base, input int cnt, input bit rnd, input logic [15:0] plan);
    int r0, i0, s0, x0, dn0, q0, sec, att, gatt, kind, k, got, n;
    bit fin;
    logic [31:0] a;
    m_req = 0; m_sdone = 0; m_disc = 0; m_done = 0; m_fail = 0; m_err = 0;
    m_addr_q.delete();
    r0 = tot_req; i0 = tot_init; s0 = tot_sdone; x0 = tot_disc; dn0 = tot_done;
    q0 = req_addr_q.size();
    base_sector = base; sector_count = cnt[15:0]; start = 1'b1;
    step();
    start = 1'b0;
    sec = 0; att = 0; gatt = 0;
    fin = (cnt == 0);
    if (fin) m_done = 1;
    while (!fin) begin
      wait_req("req_arrival");
      if (!card_req) break;
      m_req++;
      a = base + 32'(sec);
      m_addr_q.push_back(a);
      kind = rnd ? pick_kind() : int'(plan[4*((gatt < 3) ? gatt : 3) +: 4]);
      gatt++;
      step();
      if (kind != 4) begin
        k = (kind == 0) ? 512 : ((kind == 5) ? 511 : $urandom_range(0, 511));
        got = 0;
        while (got < k) begin
          buf_data_rdy = ($urandom_range(0, 3) != 0);
          card_rdy     = $urandom_range(0, 1) != 0;
          start        = rnd && ($urandom_range(0, 63) == 0);
          base_sector  = $urandom;
          if (buf_data_rdy) got++;
          step();
        end
        buf_data_rdy = 1'b0; card_rdy = 1'b0; start = 1'b0;
        if (kind != 0) begin
          buf_crc_err  = (kind == 1) || (kind == 3);
          buf_tmr_err  = (kind == 2) || (kind == 3) || (kind == 5);
          buf_data_rdy = (kind == 5);
          step();
          buf_crc_err = 1'b0; buf_tmr_err = 1'b0; buf_data_rdy = 1'b0;
        end
      end
      if (kind == 0) begin
        m_sdone++;
        sec++;
        att = 0;
        if (sec == cnt) begin
          fin = 1'b1;
          m_done = 1;
        end
      end else if (att + 1 < MAX_RETRY) begin
        att++;
        m_disc++;
      end else begin
        fin = 1'b1;
        m_fail = 1;
        m_err = ((kind == 1) || (kind == 3)) ? 1 : ((kind == 4) ? 3 : 2);
      end
    end
    n = 0;
    while (tot_done == dn0 && !fail && n < 300) begin
      step();
      n++;
    end
    repeat (3) step();
    d_req = tot_req - r0; d_init = tot_init - i0; d_sdone = tot_sdone - s0;
    d_disc = tot_disc - x0; d_done = tot_done - dn0;
    d_addr_bad = 0;
    for (int i = 0; i < m_addr_q.size(); i++) begin
      if (q0 + i >= req_addr_q.size()) d_addr_bad++;
      else if (req_addr_q[q0 + i] !== m_addr_q[i]) d_addr_bad++;
    end
  endtask

  task automatic compare_case(input int id, input int e_req, input int e_sdone, input int e_disc,
                              input int e_done, input int e_fail, input int e_err);
    chk($sformatf("c%0d_req_count", id), d_req, e_req);
    chk($sformatf("c%0d_buf_init_count", id), d_init, e_req);
    chk($sformatf("c%0d_sector_done_count", id), d_sdone, e_sdone);
    chk($sformatf("c%0d_discard_count", id), d_disc, e_disc);
    chk($sformatf("c%0d_done_count", id), d_done, e_done);
    chk($sformatf("c%0d_fail", id), fail, e_fail);
    chk($sformatf("c%0d_err_code", id), err_code, e_err);
    chk($sformatf("c%0d_busy_after", id), busy, 0);
    chk($sformatf("c%0d_addr_seq_bad", id), d_addr_bad, 0);
  endtask

  typedef struct {
    logic [31:0] base;
    int          cnt;
    logic [15:0] plan;
    int          reqs, sdone, disc, dn, fl, err;
  } vec_t;

  vec_t        tv [9];
  logic [31:0] rb;
  int          rc, dn_snap, sd_snap;

  initial begin
    // base, count, per-attempt kinds (nibble 0 = first attempt), reqs, sector_done, discard, done, fail, err
    tv[0] = '{32'h0000_0100, 2, 16'h0000, 2, 2, 0, 1, 0, 0};
    tv[1] = '{32'h0000_0055, 0, 16'h0000, 0, 0, 0, 1, 0, 0};
    tv[2] = '{32'h0000_0020, 1, 16'h0001, 2, 1, 1, 1, 0, 0};
    tv[3] = '{32'h0000_0040, 1, 16'h2222, 3, 0, 2, 0, 1, 2};
    tv[4] = '{32'h0000_0060, 1, 16'h4444, 3, 0, 2, 0, 1, 3};
    tv[5] = '{32'h0000_0070, 1, 16'h3333, 3, 0, 2, 0, 1, 1};
    tv[6] = '{32'h0000_0080, 2, 16'h0021, 4, 2, 2, 1, 0, 0};
    tv[7] = '{32'hFFFF_FFFF, 2, 16'h0005, 3, 2, 1, 1, 0, 0};
    tv[8] = '{32'h0000_0090, 2, 16'h2220, 4, 1, 2, 0, 1, 2};

    rst = 1'b0; start = 1'b0; abort = 1'b0; base_sector = '0; sector_count = '0;
    card_rdy = 1'b0; buf_data_rdy = 1'b0; buf_crc_err = 1'b0; buf_tmr_err = 1'b0;
    repeat (3) step();
    chk("reset_outputs", {card_req, buf_init, busy, sector_done, discard, done, fail, err_code, card_addr}, 0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      run_case(tv[i].base, tv[i].cnt, 1'b0, tv[i].plan);
      compare_case(i, tv[i].reqs, tv[i].sdone, tv[i].disc, tv[i].dn, tv[i].fl, tv[i].err);
    end

    // Abort while idle after a failure: buffer re-init pulse, failure status retained.
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle_buf_init", buf_init, 1);
    chk("abort_idle_fail_kept", fail, 1);
    chk("abort_idle_err_kept", err_code, 2);
    step();
    chk("abort_idle_single_pulse", buf_init, 0);

    // Latency: start -> buf_init -> card_req, last byte -> done.
    base_sector = 32'h1234; sector_count = 16'd1; start = 1'b1;
    step();
    start = 1'b0;
    chk("lat_buf_init", buf_init, 1);
    chk("lat_busy", busy, 1);
    chk("start_clears_fail", {fail, err_code}, 0);
    step();
    chk("lat_card_req", card_req, 1);
    chk("lat_card_addr", card_addr, 32'h1234);
    chk("lat_buf_init_single", buf_init, 0);
    step();
    buf_data_rdy = 1'b1; card_rdy = 1'b1;
    repeat (512) step();
    buf_data_rdy = 1'b0; card_rdy = 1'b0;
    chk("lat_done", done, 1);
    chk("lat_sector_done", sector_done, 1);
    step();
    chk("done_single_pulse", done, 0);
    chk("card_addr_held", card_addr, 32'h1234);
    chk("lat_busy_end", busy, 0);

    // Zero sectors: done on the following cycle, no card or buffer activity.
    sector_count = 16'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_no_init", buf_init, 0);
    chk("zero_no_req", card_req, 0);
    step();

    for (int i = 0; i < 6; i++) begin
      rb = (i == 0) ? 32'hFFFF_FFFE : $urandom;
      rc = $urandom_range(1, 3);
      run_case(rb, rc, 1'b1, 16'h0000);
      compare_case(100 + i, m_req, m_sdone, m_disc, m_done, m_fail, m_err);
    end

    // Abort at byte 200 of the second sector.
    base_sector = 32'h300; sector_count = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    wait_req("abort_req0");
    step();
    buf_data_rdy = 1'b1; card_rdy = 1'b1;
    repeat (512) step();
    buf_data_rdy = 1'b0; card_rdy = 1'b0;
    wait_req("abort_req1");
    chk("abort_sector1_addr", card_addr, 32'h301);
    step();
    buf_data_rdy = 1'b1; card_rdy = 1'b1;
    repeat (200) step();
    buf_data_rdy = 1'b0; card_rdy = 1'b0;
    dn_snap = tot_done; sd_snap = tot_sdone;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_buf_init", buf_init, 1);
    chk("abort_busy", busy, 0);
    repeat (5) step();
    chk("abort_no_done", tot_done - dn_snap, 0);
    chk("abort_no_sector_done", tot_sdone - sd_snap, 0);

    // Asynchronous reset in the middle of a transfer.
    base_sector = 32'h400; sector_count = 16'd1; start = 1'b1;
    step();
    start = 1'b0;
    wait_req("rst_req");
    step();
    buf_data_rdy = 1'b1; card_rdy = 1'b1;
    repeat (100) step();
    #2 rst = 1'b0;
    #1;
    chk("async_reset_outputs", {card_req, buf_init, busy, sector_done, discard, done, fail, err_code, card_addr}, 0);
    buf_data_rdy = 1'b0; card_rdy = 1'b0;
    step();
    chk("reset_hold_outputs", {card_req, buf_init, busy, sector_done, discard, done, fail, err_code, card_addr}, 0);
    rst = 1'b1;
    repeat (2) step();
    chk("post_reset_idle", {busy, done, card_req}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
